// File: rtl/instr_issue_sequencer_pkg.sv
// Shared definitions for the instruction issue sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default HALT word, CPU phase count and the
// default issue spacing derived from it.
package issue_pkg;

  // The CPU runs every instruction through id, ex, mem and wb.
  localparam int unsigned CPU_PHASES = 4;

  // One issue cycle plus one cycle per CPU phase.
  localparam int unsigned DEFAULT_CYCLES_PER_INSTR = CPU_PHASES + 1;

  // Word that terminates a program; consumed, never presented to the CPU.
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    SPACE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // States in which the sequencer is actively running a program.
  function automatic logic is_busy_state(input state_e s);
    return (s == FETCH) || (s == ISSUE) || (s == SPACE);
  endfunction

endpackage

// File: rtl/instr_issue_sequencer_fifo.sv
// Circular instruction buffer with occupancy count and full/empty flags.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   push_i, push_dat_i    enqueue request and word
//   pop_i                 dequeue request (head advances on the next edge)
//   head_dat_o            word at the read pointer (combinational read)
//   level_o               registered occupancy, 0..DEPTH
//   full_o, empty_o       decoded from level_o
module instr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rptr_q];
  assign level_o    = level_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  // A push coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Issues buffered 32-bit instruction words to a multi-cycle CPU, one per slot.
// Latency: first newinstr 2 cycles after start is sampled; then one every CYCLES_PER_INSTR.
// Backpressure: load_ready low while the buffer is full; an empty buffer stalls issue in FETCH.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   load_valid, load_word   loader offers a word; accepted when load_ready is 1
//   load_ready              buffer not full (from registered level)
//   start                   begin issuing; honoured only in IDLE or DONE
//   instrword, newinstr     word to the CPU and its one-cycle "new" pulse
//   busy, done              running / program ended on HALT_WORD
//   level                   buffer occupancy
//   issued_count            instructions issued since reset or last start
module instr_issue_sequencer
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned CYCLES_PER_INSTR = DEFAULT_CYCLES_PER_INSTR,
  parameter logic [31:0] HALT_WORD        = DEFAULT_HALT_WORD
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [31:0]            load_word,
  output logic                   load_ready,
  input  logic                   start,
  output logic [31:0]            instrword,
  output logic                   newinstr,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            issued_count
);

  // Wide enough to hold CYCLES_PER_INSTR-2 for any legal setting (>= 3).
  localparam int unsigned CW = $clog2(CYCLES_PER_INSTR);

  state_e        state_q, state_d;
  logic [CW-1:0] space_q, space_d;
  logic [31:0]   instrword_q, instrword_d;
  logic          newinstr_q, newinstr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   issued_q, issued_d;

  logic          fifo_pop;
  logic [31:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .push_i     (load_valid),
    .push_dat_i (load_word),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .level_o    (level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign load_ready   = ~fifo_full;
  assign instrword    = instrword_q;
  assign newinstr     = newinstr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = issued_q;

  // Next-state logic. Registered outputs are computed from the state being
  // entered, so newinstr is high exactly during the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    space_d     = space_q;
    instrword_d = instrword_q;
    newinstr_d  = 1'b0;
    issued_d    = issued_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = FETCH;
          issued_d = '0;
        end
      end

      FETCH: begin
        // Emptiness uses the registered level, so a word pushed this cycle
        // can only be popped next cycle.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_head == HALT_WORD) begin
            state_d = DONE;
          end else begin
            instrword_d = fifo_head;
            newinstr_d  = 1'b1;
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: begin
        issued_d = issued_q + 16'd1;
        // SPACE lasts CYCLES_PER_INSTR-2 cycles; with ISSUE and FETCH that
        // makes the full slot.
        space_d  = CW'(CYCLES_PER_INSTR - 2);
        state_d  = SPACE;
      end

      SPACE: begin
        space_d = space_q - 1'b1;
        // "<=" guards against a zero count ever trapping the FSM here.
        if (space_q <= CW'(1)) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase

    busy_d = is_busy_state(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      space_q     <= '0;
      instrword_q <= '0;
      newinstr_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      space_q     <= space_d;
      instrword_q <= instrword_d;
      newinstr_q  <= newinstr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issued_q    <= issued_d;
    end
  end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
module tb_instr_issue_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } exp_t;

  logic        clock;
  logic        reset;

  // Default instance (CYCLES_PER_INSTR = 5)
  logic        load_valid, load_ready, start, newinstr, busy, done;
  logic [31:0] load_word, instrword;
  logic [4:0]  level;
  logic [15:0] issued_count;

  // Instance with CYCLES_PER_INSTR = 3
  logic        load_valid3, load_ready3, start3, newinstr3, busy3, done3;
  logic [31:0] load_word3, instrword3;
  logic [4:0]  level3;
  logic [15:0] issued_count3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q5[$];
  exp_t q3[$];
  exp_t e5, e3;

  instr_issue_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_word    (load_word),
    .load_ready   (load_ready),
    .start        (start),
    .instrword    (instrword),
    .newinstr     (newinstr),
    .busy         (busy),
    .done         (done),
    .level        (level),
    .issued_count (issued_count)
  );

  instr_issue_sequencer #(.CYCLES_PER_INSTR(3)) dut3 (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid3),
    .load_word    (load_word3),
    .load_ready   (load_ready3),
    .start        (start3),
    .instrword    (instrword3),
    .newinstr     (newinstr3),
    .busy         (busy3),
    .done         (done3),
    .level        (level3),
    .issued_count (issued_count3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every newinstr pulse must match the next scoreboard entry.
  always @(negedge clock) begin
    if (newinstr === 1'b1) begin
      if (q5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_newinstr: word %0h at cycle %0d, none expected", instrword, cyc);
      end else begin
        e5 = q5.pop_front();
        check("issue_word", instrword, e5.word);
        check("issue_cycle", cyc, e5.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (newinstr3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_newinstr3: word %0h at cycle %0d, none expected", instrword3, cyc);
      end else begin
        e3 = q3.pop_front();
        check("issue3_word", instrword3, e3.word);
        check("issue3_cycle", cyc, e3.cyc);
      end
    end
  end

  // Offer one word for the next edge; returns at the following negedge.
  task automatic push_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_word  = w;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic push_word3(input logic [31:0] w);
    load_valid3 = 1'b1;
    load_word3  = w;
    @(negedge clock);
    load_valid3 = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound && done !== 1'b1; n++) @(negedge clock);
  endtask

  task automatic wait_q5_empty(input int bound);
    for (int n = 0; n < bound && q5.size() != 0; n++) @(negedge clock);
  endtask

  initial begin
    int k, p, q, acc;

    reset = 1'b1;
    load_valid = 1'b0;  load_word = '0;  start = 1'b0;
    load_valid3 = 1'b0; load_word3 = '0; start3 = 1'b0;
    repeat (2) @(negedge clock);
    // Push coinciding with reset must be dropped.
    load_valid  = 1'b1; load_word  = 32'hDEAD_BEEF;
    load_valid3 = 1'b1; load_word3 = 32'hDEAD_BEEF;
    @(negedge clock);
    reset = 1'b0; load_valid = 1'b0; load_valid3 = 1'b0;

    check("rst_level", level, 0);
    check("rst_instrword", instrword, 0);
    check("rst_newinstr", newinstr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_issued", issued_count, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_level3", level3, 0);

    // Basic program: two instructions then HALT.
    push_word(32'h0022_1820);
    push_word(32'h8C01_0004);
    push_word(HALT);
    check("t1_level_loaded", level, 3);
    start = 1'b1;
    k = cyc;
    q5.push_back('{k + 2, 32'h0022_1820});
    q5.push_back('{k + 7, 32'h8C01_0004});
    @(negedge clock);
    start = 1'b0;
    wait_done(60);
    check("t1_done", done, 1);
    check("t1_done_cycle", cyc, k + 12);
    check("t1_issued", issued_count, 2);
    check("t1_level", level, 0);
    check("t1_busy", busy, 0);
    check("t1_instrword_held", instrword, 32'h8C01_0004);

    // Fill past capacity: 17 offers, 16 accepts; pointers also wrap here.
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_word  = 32'h0000_1000 + i;
      if (load_ready === 1'b1) acc++;
      @(negedge clock);
    end
    load_valid = 1'b0;
    check("fill_accepts", acc, 16);
    check("fill_load_ready", load_ready, 0);
    check("fill_level", level, 16);

    // Issue all 16 buffered words back-to-back from DONE.
    start = 1'b1;
    k = cyc;
    for (int i = 0; i < 16; i++) q5.push_back('{k + 2 + 5 * i, 32'h0000_1000 + i});
    @(negedge clock);
    start = 1'b0;
    wait_q5_empty(200);
    check("fill_all_issued", q5.size(), 0);
    check("fill_issued_count", issued_count, 16);
    repeat (6) @(negedge clock);

    // Starved FETCH; a start offered while busy must be ignored.
    check("starve_busy", busy, 1);
    p = cyc;
    load_valid = 1'b1; load_word = 32'hAC02_0008; start = 1'b1;
    q5.push_back('{p + 2, 32'hAC02_0008});
    @(negedge clock);
    load_valid = 1'b0; start = 1'b0;
    wait_q5_empty(20);
    repeat (2) @(negedge clock);
    check("starve_issued_count", issued_count, 17);

    // Simultaneous push and pop in FETCH with level 1.
    repeat (4) @(negedge clock);
    q = cyc;
    q5.push_back('{q + 2, 32'h1111_0001});
    q5.push_back('{q + 7, 32'h2222_0002});
    load_valid = 1'b1; load_word = 32'h1111_0001;
    @(negedge clock);
    load_word = 32'h2222_0002;
    @(negedge clock);
    check("pushpop_level", level, 1);
    load_word = HALT;
    @(negedge clock);
    load_valid = 1'b0;
    wait_done(40);
    check("pushpop_done_cycle", cyc, q + 12);
    check("pushpop_issued", issued_count, 19);
    check("pushpop_level_end", level, 0);

    // Reset in the middle of SPACE with three words still buffered.
    push_word(32'h0000_2000);
    push_word(32'h0000_2001);
    push_word(32'h0000_2002);
    push_word(32'h0000_2003);
    start = 1'b1;
    k = cyc;
    q5.push_back('{k + 2, 32'h0000_2000});
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_pre_level", level, 3);
    check("midrst_pre_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_level", level, 0);
    check("midrst_instrword", instrword, 0);
    check("midrst_busy", busy, 0);
    check("midrst_issued", issued_count, 0);
    check("midrst_done", done, 0);
    check("midrst_load_ready", load_ready, 1);
    repeat (8) @(negedge clock);
    check("midrst_stays_idle", busy, 0);

    // CYCLES_PER_INSTR = 3: pulses exactly 3 cycles apart.
    push_word3(32'h0000_3000);
    push_word3(32'h0000_3001);
    push_word3(32'h0000_3002);
    push_word3(32'h0000_3003);
    push_word3(HALT);
    start3 = 1'b1;
    k = cyc;
    for (int i = 0; i < 4; i++) q3.push_back('{k + 2 + 3 * i, 32'h0000_3000 + i});
    @(negedge clock);
    start3 = 1'b0;
    for (int n = 0; n < 40 && done3 !== 1'b1; n++) @(negedge clock);
    check("cpi3_done_cycle", cyc, k + 14);
    check("cpi3_issued", issued_count3, 4);
    check("cpi3_level", level3, 0);

    repeat (3) @(negedge clock);
    check("sb5_drained", q5.size(), 0);
    check("sb3_drained", q3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
